serial_add_sub_digit: RTL and testbench
=======================================

// Module: serial_add_sub_digit
// PURPOSE
//  Digit-serial adder/subtractor, the parametrised successor of the 1-bit serial adder.
//  - Each word arrives LSB digit first: DIGIT_W bits per accepted beat, WORD_DIGITS beats per word.
//  - Per word, the block produces registered sum digits, the assembled parallel result, and
//    end-of-word carry/overflow flags.
//  - Sits between serialising front-ends and parallel consumers in the sequential arithmetic path.
// PARAMETERS
//  DIGIT_W      4  bits processed per beat (>=1)
//  WORD_DIGITS  2  beats per word (>=1); word width W = DIGIT_W*WORD_DIGITS
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        beat present on a/b this cycle
//  in_first   in   1        beat is digit 0 of a new word
//  in_sub     in   1        mode, sampled on first beat only: 1 = a-b, 0 = a+b
//  a, b       in   DIGIT_W  operand digits
//  out_valid  out  1        sum digit valid
//  sum        out  DIGIT_W  result digit
//  out_last   out  1        sum is the final digit of the word
//  word_valid out  1        pulse: word_sum/carry_out/overflow valid (same cycle as out_last)
//  word_sum   out  W        assembled result, digit k in bits [k*DIGIT_W +: DIGIT_W]
//  carry_out  out  1        carry out of the MSB (subtract: 1 = no borrow)
//  overflow   out  1        signed overflow of the W-bit operation
//  frame_err  out  1        pulse: framing violation detected
// BEHAVIOUR
//  - Adder core uses only ^ | & ~; no + or - operators.
//  - Subtract = a + ~b with carry-in 1; add uses carry-in 0.
//  - FSM states IDLE, BUSY. Digit counter cnt counts 0..WORD_DIGITS-1. Mode reg and carry reg.
//  - IDLE:
//    - in_valid & in_first: accept digit 0, load mode = in_sub, carry-in = in_sub.
//      Go to BUSY, or stay in IDLE if WORD_DIGITS==1.
//    - in_valid & ~in_first: beat dropped, frame_err=1 next cycle, no out_valid.
//  - BUSY:
//    - in_valid & ~in_first: accept digit cnt; carry reg <= digit carry-out.
//    - Last beat (cnt==WORD_DIGITS-1) returns the FSM to IDLE; cnt wraps to 0.
//    - in_valid & in_first: abort the current word (no word_valid), frame_err=1 next cycle;
//      the beat is accepted as digit 0 of a new word.
//  - in_valid=0: stall. Counter, carry, mode and partial word_sum hold; outputs deassert
//    out_valid/out_last/word_valid.
//  - Latency: every output is registered one cycle after the accepted beat.
//    Throughput is one digit per cycle, no backpressure.
//  - Last beat: out_last=word_valid=1.
//    - carry_out = MSB carry.
//    - overflow = carry into MSB ^ carry out of MSB.
//    - word_sum holds all digits including the current one.
//  - word_sum, carry_out and overflow hold their values until the next word's last beat.
//  - Reset (any time, including mid-word):
//    - state=IDLE, cnt=0, carry=0, mode=0.
//    - All outputs 0; the partial word is discarded.
// STRUCTURE
//  - Package serial_arith_pkg: typedef enum logic {IDLE, BUSY} ser_state_t;
//    localparam function for counter width $clog2(WORD_DIGITS) (min 1).
//  - Sub-module full_adder_bit (a, b, cin -> s, cout; gate-level).
//    Instantiate DIGIT_W copies in a generate ripple chain.
//  - Top holds the FSM, counter, carry/mode registers, word_sum shift/insert register and flags.
// TESTING (DIGIT_W=4, WORD_DIGITS=2 unless stated)
//  1. Add 0x5A+0x3C (digits A/C then 5/3): sum 6, then 9.
//     word_sum=0x96, carry_out=0, overflow=1.
//  2. Sub 0x10-0x01: word_sum=0x0F, carry_out=1, overflow=0.
//     Sub 0x80-0x01: word_sum=0x7F, carry_out=1, overflow=1.
//  3. Stall: 0x5A+0x3C with 3 idle cycles between digits gives the same result as test 1.
//     out_valid high for exactly 2 cycles.
//  4. Framing:
//     - Digit 1 without in_first in IDLE -> frame_err pulse, no outputs.
//     - in_first mid-word -> frame_err, no word_valid; the new word completes correctly.
//  5. rst asserted after digit 0 of 0xFF+0x01 -> all outputs 0.
//     The next word 0x01+0x01 gives 0x02 with carry 0; no stale carry.
//  6. DIGIT_W=1, WORD_DIGITS=8: random 1000 add/sub words vs reference model.
//     Then DIGIT_W=8, WORD_DIGITS=1: word_valid on every beat.

Source files
------------

// File: rtl/serial_add_sub_digit_pkg.sv
// Shared types and helpers for the digit-serial arithmetic path.
//   ser_state_t : word framing state (IDLE between words, BUSY mid-word)
//   cnt_width() : digit-counter width for a given word length, never below 1
package serial_arith_pkg;

  typedef enum logic {IDLE, BUSY} ser_state_t;

  function automatic int unsigned cnt_width(input int unsigned digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/serial_add_sub_digit_fa.sv
// Gate-level one-bit full adder, the ripple element of the digit adder.
//   a, b, cin : operand bits and carry in
//   s, cout   : sum bit and carry out
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (p & cin);

endmodule

// File: rtl/serial_add_sub_digit.sv
// Digit-serial adder/subtractor. Words arrive LSB digit first, DIGIT_W bits
// per accepted beat, WORD_DIGITS beats per word. All outputs are registered
// one cycle after the accepted beat.
//   clk, rst                  : clock, synchronous active-high reset
//   in_valid/in_first/in_sub  : beat strobe, digit-0 marker, mode (1 = a-b)
//   a, b                      : operand digits
//   out_valid/sum/out_last    : registered result digit and its framing
//   word_valid/word_sum       : assembled result pulse and value
//   carry_out/overflow        : MSB carry (subtract: 1 = no borrow), signed ovf
//   frame_err                 : framing violation pulse
module serial_add_sub_digit
  import serial_arith_pkg::*;
#(
  parameter int unsigned DIGIT_W     = 4,
  parameter int unsigned WORD_DIGITS = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic                             in_first,
  input  logic                             in_sub,
  input  logic [DIGIT_W-1:0]               a,
  input  logic [DIGIT_W-1:0]               b,
  output logic                             out_valid,
  output logic [DIGIT_W-1:0]               sum,
  output logic                             out_last,
  output logic                             word_valid,
  output logic [DIGIT_W*WORD_DIGITS-1:0]   word_sum,
  output logic                             carry_out,
  output logic                             overflow,
  output logic                             frame_err
);

  localparam int unsigned    W        = DIGIT_W * WORD_DIGITS;
  localparam int unsigned    CW       = cnt_width(WORD_DIGITS);
  localparam logic [CW-1:0]  LAST_IDX = CW'(WORD_DIGITS - 1);

  ser_state_t        state, state_next;
  logic [CW-1:0]     cnt;
  logic              carry;
  logic              mode;
  logic [W-1:0]      acc;

  logic              first_beat;
  logic              accept;
  logic              drop;
  logic              abort;
  logic              last_beat;
  logic              mode_eff;
  logic              cin;
  logic [CW-1:0]     idx;

  logic [DIGIT_W-1:0] b_eff;
  logic [DIGIT_W-1:0] digit_sum;
  logic [DIGIT_W:0]   c;
  logic [W-1:0]       acc_ins;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state: a digit-0 beat always restarts a word, so a single-digit word
  // never leaves IDLE and an in_first beat mid-word keeps the FSM in BUSY.
  always_comb begin
    state_next = state;
    if (accept) state_next = last_beat ? IDLE : BUSY;
  end

  // Beat decode
  always_comb begin
    first_beat = in_valid & in_first;
    accept     = first_beat | (in_valid & (state == BUSY));
    drop       = in_valid & ~in_first & (state == IDLE);
    abort      = first_beat & (state == BUSY);
    idx        = first_beat ? '0 : cnt;
    last_beat  = accept & (idx == LAST_IDX);
    mode_eff   = first_beat ? in_sub : mode;
    cin        = first_beat ? in_sub : carry;
  end

  // Digit adder: subtraction is a + ~b with the word's carry-in forced to 1.
  assign b_eff = b ^ {DIGIT_W{mode_eff}};
  assign c[0]  = cin;

  for (genvar i = 0; i < DIGIT_W; i++) begin : g_ripple
    full_adder_bit u_fa (
      .a   (a[i]),
      .b   (b_eff[i]),
      .cin (c[i]),
      .s   (digit_sum[i]),
      .cout(c[i+1])
    );
  end

  // Insert the current digit at its position in the partial word. After an
  // abort, higher digits still hold the discarded word until overwritten.
  always_comb begin
    acc_ins = acc;
    for (int unsigned k = 0; k < WORD_DIGITS; k++) begin
      if (idx == CW'(k)) acc_ins[k*DIGIT_W +: DIGIT_W] = digit_sum;
    end
  end

  // Word-progress registers; all hold across stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      carry <= 1'b0;
      mode  <= 1'b0;
      acc   <= '0;
    end else if (accept) begin
      cnt   <= last_beat ? '0 : idx + CW'(1);
      carry <= c[DIGIT_W];
      mode  <= mode_eff;
      acc   <= acc_ins;
    end
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      sum        <= '0;
      out_last   <= 1'b0;
      word_valid <= 1'b0;
      word_sum   <= '0;
      carry_out  <= 1'b0;
      overflow   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      out_valid  <= accept;
      out_last   <= last_beat;
      word_valid <= last_beat;
      frame_err  <= drop | abort;
      if (accept) sum <= digit_sum;
      if (last_beat) begin
        word_sum  <= acc_ins;
        carry_out <= c[DIGIT_W];
        overflow  <= c[DIGIT_W] ^ c[DIGIT_W-1];
      end
    end
  end

endmodule

// File: tb/tb_serial_add_sub_digit.sv
module tb_serial_add_sub_digit;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // DIGIT_W=4, WORD_DIGITS=2
  logic       d_in_valid, d_in_first, d_in_sub;
  logic [3:0] d_a, d_b, d_sum;
  logic       d_out_valid, d_out_last, d_word_valid, d_carry_out, d_overflow, d_frame_err;
  logic [7:0] d_word_sum;

  // DIGIT_W=1, WORD_DIGITS=8
  logic       s_in_valid, s_in_first, s_in_sub;
  logic [0:0] s_a, s_b, s_sum;
  logic       s_out_valid, s_out_last, s_word_valid, s_carry_out, s_overflow, s_frame_err;
  logic [7:0] s_word_sum;

  // DIGIT_W=8, WORD_DIGITS=1
  logic       w_in_valid, w_in_first, w_in_sub;
  logic [7:0] w_a, w_b, w_sum;
  logic       w_out_valid, w_out_last, w_word_valid, w_carry_out, w_overflow, w_frame_err;
  logic [7:0] w_word_sum;

  serial_add_sub_digit #(.DIGIT_W(4), .WORD_DIGITS(2)) u_d (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_first(d_in_first), .in_sub(d_in_sub),
    .a(d_a), .b(d_b), .out_valid(d_out_valid), .sum(d_sum), .out_last(d_out_last),
    .word_valid(d_word_valid), .word_sum(d_word_sum), .carry_out(d_carry_out),
    .overflow(d_overflow), .frame_err(d_frame_err)
  );

  serial_add_sub_digit #(.DIGIT_W(1), .WORD_DIGITS(8)) u_s (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_first(s_in_first), .in_sub(s_in_sub),
    .a(s_a), .b(s_b), .out_valid(s_out_valid), .sum(s_sum), .out_last(s_out_last),
    .word_valid(s_word_valid), .word_sum(s_word_sum), .carry_out(s_carry_out),
    .overflow(s_overflow), .frame_err(s_frame_err)
  );

  serial_add_sub_digit #(.DIGIT_W(8), .WORD_DIGITS(1)) u_w (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_first(w_in_first), .in_sub(w_in_sub),
    .a(w_a), .b(w_b), .out_valid(w_out_valid), .sum(w_sum), .out_last(w_out_last),
    .word_valid(w_word_valid), .word_sum(w_word_sum), .carry_out(w_carry_out),
    .overflow(w_overflow), .frame_err(w_frame_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // {out_valid, sum (only while valid), out_last, word_valid, word_sum, carry_out, overflow, frame_err}
  function automatic logic [31:0] d_pack();
    return 32'({d_out_valid, (d_out_valid ? d_sum : 4'h0), d_out_last, d_word_valid,
                d_word_sum, d_carry_out, d_overflow, d_frame_err});
  endfunction

  typedef struct {
    logic       r, v, f, s;
    logic [3:0] a, b;
    logic       ov;
    logic [3:0] sum;
    logic       last, wv;
    logic [7:0] ws;
    logic       co, of, fe;
  } vec_t;

  function automatic vec_t mk(input logic r, v, f, s, input logic [3:0] a, b,
                              input logic ov, input logic [3:0] sum, input logic last, wv,
                              input logic [7:0] ws, input logic co, of, fe);
    vec_t t;
    t.r = r; t.v = v; t.f = f; t.s = s; t.a = a; t.b = b;
    t.ov = ov; t.sum = sum; t.last = last; t.wv = wv; t.ws = ws;
    t.co = co; t.of = of; t.fe = fe;
    return t;
  endfunction

  vec_t tbl[$];

  logic [7:0] ra, rb, r8, got;
  logic [8:0] s9;
  logic       rsub, eco, eof, ok;

  logic [7:0] wa [4] = '{8'h7F, 8'h00, 8'hFF, 8'h80};
  logic [7:0] wb [4] = '{8'h01, 8'h01, 8'h01, 8'h01};
  logic       ws_[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] we [4] = '{8'h80, 8'hFF, 8'h00, 8'h7F};
  logic       wco[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic       wof[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    //                 r v f s  a     b    ov sum  lst wv ws     co of fe
    // 0x5A + 0x3C
    tbl.push_back(mk(0,1,1,0, 4'hA,4'hC, 1,4'h6, 0,0, 8'h00, 0,0,0));
    tbl.push_back(mk(0,1,0,0, 4'h5,4'h3, 1,4'h9, 1,1, 8'h96, 0,1,0));
    // 0x10 - 0x01 (in_sub low on digit 1: mode must be held)
    tbl.push_back(mk(0,1,1,1, 4'h0,4'h1, 1,4'hF, 0,0, 8'h96, 0,1,0));
    tbl.push_back(mk(0,1,0,0, 4'h1,4'h0, 1,4'h0, 1,1, 8'h0F, 1,0,0));
    // 0x80 - 0x01
    tbl.push_back(mk(0,1,1,1, 4'h0,4'h1, 1,4'hF, 0,0, 8'h0F, 1,0,0));
    tbl.push_back(mk(0,1,0,0, 4'h8,4'h0, 1,4'h7, 1,1, 8'h7F, 1,1,0));
    // 0x5A + 0x3C with 3 stall cycles between digits
    tbl.push_back(mk(0,1,1,0, 4'hA,4'hC, 1,4'h6, 0,0, 8'h7F, 1,1,0));
    tbl.push_back(mk(0,0,1,1, 4'h7,4'h7, 0,4'h0, 0,0, 8'h7F, 1,1,0));
    tbl.push_back(mk(0,0,1,1, 4'h7,4'h7, 0,4'h0, 0,0, 8'h7F, 1,1,0));
    tbl.push_back(mk(0,0,1,1, 4'h7,4'h7, 0,4'h0, 0,0, 8'h7F, 1,1,0));
    tbl.push_back(mk(0,1,0,0, 4'h5,4'h3, 1,4'h9, 1,1, 8'h96, 0,1,0));
    // digit without in_first while idle: dropped, frame_err pulse
    tbl.push_back(mk(0,1,0,0, 4'h5,4'h3, 0,4'h0, 0,0, 8'h96, 0,1,1));
    tbl.push_back(mk(0,0,0,0, 4'h0,4'h0, 0,4'h0, 0,0, 8'h96, 0,1,0));
    // aborted subtract F-F (carry 1), then 0x12 + 0x34 restarts mid-word
    tbl.push_back(mk(0,1,1,1, 4'hF,4'hF, 1,4'h0, 0,0, 8'h96, 0,1,0));
    tbl.push_back(mk(0,1,1,0, 4'h2,4'h4, 1,4'h6, 0,0, 8'h96, 0,1,1));
    tbl.push_back(mk(0,1,0,0, 4'h1,4'h3, 1,4'h4, 1,1, 8'h46, 0,0,0));
    // 0xFF + 0x01 digit 0, then reset (with a beat present) mid-word
    tbl.push_back(mk(0,1,1,0, 4'hF,4'h1, 1,4'h0, 0,0, 8'h46, 0,0,0));
    tbl.push_back(mk(1,1,0,0, 4'h0,4'h0, 0,4'h0, 0,0, 8'h00, 0,0,0));
    // 0x01 + 0x01 after reset
    tbl.push_back(mk(0,1,1,0, 4'h1,4'h1, 1,4'h2, 0,0, 8'h00, 0,0,0));
    tbl.push_back(mk(0,1,0,0, 4'h0,4'h0, 1,4'h0, 1,1, 8'h02, 0,0,0));

    rst = 1'b1;
    {d_in_valid, d_in_first, d_in_sub, d_a, d_b} = '0;
    {s_in_valid, s_in_first, s_in_sub, s_a, s_b} = '0;
    {w_in_valid, w_in_first, w_in_sub, w_a, w_b} = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_d", d_pack(), 32'h0);
    check("reset_s", 32'({s_out_valid, s_sum, s_out_last, s_word_valid, s_word_sum,
                          s_carry_out, s_overflow, s_frame_err}), 32'h0);
    check("reset_w", 32'({w_out_valid, w_sum, w_out_last, w_word_valid, w_word_sum,
                          w_carry_out, w_overflow, w_frame_err}), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors, DIGIT_W=4 WORD_DIGITS=2
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst        = tbl[i].r;
      d_in_valid = tbl[i].v;
      d_in_first = tbl[i].f;
      d_in_sub   = tbl[i].s;
      d_a        = tbl[i].a;
      d_b        = tbl[i].b;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), d_pack(),
            32'({tbl[i].ov, tbl[i].sum, tbl[i].last, tbl[i].wv, tbl[i].ws,
                 tbl[i].co, tbl[i].of, tbl[i].fe}));
    end
    @(negedge clk);
    rst = 1'b0;
    d_in_valid = 1'b0;

    // DIGIT_W=1 WORD_DIGITS=8: random words with random stalls vs arithmetic model
    for (int n = 0; n < 1000; n++) begin
      ra   = 8'($urandom_range(0, 255));
      rb   = 8'($urandom_range(0, 255));
      rsub = 1'($urandom_range(0, 1));
      if (rsub) begin
        r8  = ra - rb;
        eco = (ra >= rb);
        eof = (ra[7] != rb[7]) && (r8[7] != ra[7]);
      end else begin
        s9  = {1'b0, ra} + {1'b0, rb};
        r8  = s9[7:0];
        eco = s9[8];
        eof = (ra[7] == rb[7]) && (r8[7] != ra[7]);
      end
      ok  = 1'b1;
      got = '0;
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 4) == 0) begin
          @(negedge clk);
          s_in_valid = 1'b0;
          s_in_first = 1'b1;
          @(posedge clk);
          #1;
          if (s_out_valid || s_word_valid || s_frame_err) ok = 1'b0;
        end
        @(negedge clk);
        s_in_valid = 1'b1;
        s_in_first = (k == 0);
        s_in_sub   = (k == 0) ? rsub : ~rsub;
        s_a        = ra[k];
        s_b        = rb[k];
        @(posedge clk);
        #1;
        got[k] = s_sum[0];
        if (!s_out_valid || (s_out_last != (k == 7)) || (s_word_valid != (k == 7)) || s_frame_err)
          ok = 1'b0;
      end
      check($sformatf("rand%0d", n), 32'({ok, got, s_word_sum, s_carry_out, s_overflow}),
            32'({1'b1, r8, r8, eco, eof}));
    end
    @(negedge clk);
    s_in_valid = 1'b0;

    // DIGIT_W=8 WORD_DIGITS=1: every beat is a whole word
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      w_in_valid = 1'b1;
      w_in_first = 1'b1;
      w_in_sub   = ws_[i];
      w_a        = wa[i];
      w_b        = wb[i];
      @(posedge clk);
      #1;
      check($sformatf("single%0d", i),
            32'({w_out_valid, w_sum, w_out_last, w_word_valid, w_word_sum,
                 w_carry_out, w_overflow, w_frame_err}),
            32'({1'b1, we[i], 1'b1, 1'b1, we[i], wco[i], wof[i], 1'b0}));
    end
    @(negedge clk);
    w_in_first = 1'b0;
    w_a        = 8'h11;
    w_b        = 8'h22;
    @(posedge clk);
    #1;
    check("single_noframe",
          32'({w_out_valid, w_out_last, w_word_valid, w_word_sum, w_carry_out, w_overflow, w_frame_err}),
          32'({1'b0, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b1}));
    @(negedge clk);
    w_in_valid = 1'b0;
    @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
